// File: rtl/adc_monitor.sv
// ADC stream monitor: windowed overflow count and peak magnitude, plus
// programmable per-channel level counters.
module adc_monitor #(
  parameter int unsigned ADC_BITS = 14,
  parameter int unsigned WIN_BITS = 16,
  parameter int unsigned NLVL     = 2
) (
  input  logic                       adc_clk,
  input  logic                       rst,
  input  logic signed [ADC_BITS-1:0] adc_data,
  input  logic                       adc_ovfl,
  input  logic                       cfg_wr,
  input  logic [3:0]                 cfg_addr,
  input  logic [31:0]                cfg_data,
  input  logic                       cnt_clr,
  output logic                       win_done,
  output logic                       ovfl_A,
  output logic [WIN_BITS:0]          ovfl_cnt,
  output logic [ADC_BITS-2:0]        peak_mag,
  output logic [NLVL*32-1:0]         lvl_cnt
);

  localparam int unsigned MAG_BITS = ADC_BITS - 1;
  localparam int unsigned CNT_BITS = WIN_BITS + 1;

  logic [WIN_BITS-1:0] win_cnt;
  logic [CNT_BITS-1:0] run_cnt;
  logic [MAG_BITS-1:0] run_pk;
  logic [CNT_BITS-1:0] ovfl_mask;
  logic [MAG_BITS-1:0] thr_q  [NLVL];
  logic                mode_q [NLVL];

  logic [ADC_BITS-1:0] neg_c;
  logic [MAG_BITS-1:0] mag_c;
  logic [CNT_BITS-1:0] run_cnt_nxt_c;
  logic [MAG_BITS-1:0] run_pk_nxt_c;
  logic                terminal_c;
  logic                mask_wr_c;
  logic                lvl_inc_c [NLVL];
  logic                lvl_wr_c  [NLVL];
  logic                unused_cfg_c;

  // Only low config bits are meaningful; the reduction keeps the rest visible.
  assign unused_cfg_c = ^cfg_data;

  // Magnitude of the signed sample; the most-negative code saturates to all ones.
  always_comb begin
    neg_c = ADC_BITS'(~$unsigned(adc_data)) + ADC_BITS'(1);
    mag_c = $unsigned(adc_data[MAG_BITS-1:0]);
    if (adc_data[ADC_BITS-1]) begin
      mag_c = neg_c[ADC_BITS-1] ? '1 : neg_c[MAG_BITS-1:0];
    end
  end

  // Running window accumulators including the current sample.
  always_comb begin
    terminal_c    = &win_cnt;
    mask_wr_c     = cfg_wr && (cfg_addr == 4'd0);
    run_cnt_nxt_c = run_cnt + CNT_BITS'(adc_ovfl);
    run_pk_nxt_c  = (mag_c > run_pk) ? mag_c : run_pk;
  end

  // Window counter, running stats and end-of-window result capture.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      win_cnt   <= '0;
      run_cnt   <= '0;
      run_pk    <= '0;
      ovfl_cnt  <= '0;
      peak_mag  <= '0;
      win_done  <= 1'b0;
      ovfl_A    <= 1'b0;
      ovfl_mask <= '1;
    end else begin
      win_cnt  <= win_cnt + WIN_BITS'(1);
      win_done <= 1'b0;
      ovfl_A   <= 1'b0;
      if (mask_wr_c) begin
        ovfl_mask <= cfg_data[WIN_BITS:0];
      end
      if (terminal_c) begin
        ovfl_cnt <= run_cnt_nxt_c;
        peak_mag <= run_pk_nxt_c;
        win_done <= 1'b1;
        ovfl_A   <= |(run_cnt_nxt_c & ovfl_mask);
        run_cnt  <= '0;
        run_pk   <= '0;
      end else begin
        run_cnt <= run_cnt_nxt_c;
        run_pk  <= run_pk_nxt_c;
      end
    end
  end

  // Per-channel increment and config-write decode using the current thr/mode.
  always_comb begin
    for (int k = 0; k < NLVL; k++) begin
      lvl_wr_c[k]  = cfg_wr && (cfg_addr == 4'(k + 1));
      lvl_inc_c[k] = mode_q[k] ? adc_ovfl : (mag_c >= thr_q[k]);
    end
  end

  // Level channel configuration and counters; clears win over increments.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      lvl_cnt <= '0;
      for (int k = 0; k < NLVL; k++) begin
        thr_q[k]  <= '1;
        mode_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NLVL; k++) begin
        if (lvl_wr_c[k]) begin
          thr_q[k]  <= cfg_data[ADC_BITS-2:0];
          mode_q[k] <= cfg_data[ADC_BITS-1];
        end
        if (lvl_wr_c[k] || cnt_clr) begin
          lvl_cnt[32*k +: 32] <= '0;
        end else begin
          lvl_cnt[32*k +: 32] <= lvl_cnt[32*k +: 32] + 32'(lvl_inc_c[k]);
        end
      end
    end
  end

endmodule
